// File: rtl/instr_mem_pipelined.sv
// Pipelined instruction memory for the fetch stage.
// The request enters stage 0, which doubles as the array read register, and
// walks READ_LATENCY stages to the response port. A response that is not taken
// freezes the whole pipe; the load port writes independently of that freeze.
module instr_mem_pipelined #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W+1:0]   req_addr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_instr,
  output logic                rsp_fault,
  input  logic                ld_en,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_data
);

  localparam int L = READ_LATENCY;
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic              vld;
    logic              fault;
    logic [DATA_W-1:0] data;
  } stage_t;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  stage_t [L-1:0]    stage_q, stage_d;
  logic              stall;
  logic [ADDR_W-1:0] req_idx;
  logic              req_fault;

  assign stall     = stage_q[L-1].vld & ~rsp_ready;
  assign req_ready = ~stall;
  assign req_idx   = req_addr[ADDR_W+1:2];
  assign req_fault = (req_addr[1:0] != 2'b00) | ({1'b0, req_idx} >= DEPTH_W);

  assign rsp_valid = stage_q[L-1].vld;
  assign rsp_fault = stage_q[L-1].fault;
  assign rsp_instr = stage_q[L-1].data;

  // Next pipe contents: hold everything on stall, otherwise shift by one.
  // Invalid and faulting slots carry zero data so outputs are clean.
  always_comb begin
    stage_d = stage_q;
    if (!stall) begin
      stage_d[0].vld   = req_valid;
      stage_d[0].fault = req_valid & req_fault;
      stage_d[0].data  = (req_valid & ~req_fault) ? mem[req_idx] : '0;
      for (int i = 1; i < L; i++) stage_d[i] = stage_q[i-1];
    end
  end

  // Pipe register; reset drops every in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q <= '0;
    else        stage_q <= stage_d;
  end

  // Array write port; not reset. The stage-0 read above samples the old word
  // on a same-edge write, giving read-before-write.
  always_ff @(posedge clk) begin
    if (ld_en && ({1'b0, ld_addr} < DEPTH_W)) mem[ld_addr] <= ld_data;
  end

endmodule

// File: tb/tb_instr_mem_pipelined.sv
// Bench for instr_mem_pipelined: four instances (latency 1..4, the last with
// DEPTH=16) share request/load stimulus; each has its own rsp_ready and its own
// queue-based reference model that predicts valid, data, fault and latency.
module tb_instr_mem_pipelined;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic [6:0]        req_addr;
  logic              ld_en;
  logic [4:0]        ld_addr;
  logic [31:0]       ld_data;
  logic [3:0]        rsp_ready;
  logic [3:0]        req_ready, rsp_valid, rsp_fault;
  logic [3:0][31:0]  rsp_instr;
  bit                drain_chk = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic        f;
    logic [31:0] d;
    int          ae;   // edge index at which the request was accepted
    int          as;   // stall edges seen before acceptance
  } exp_t;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int L = k + 1;
    localparam int D = (k == 3) ? 16 : 32;

    instr_mem_pipelined #(
      .DATA_W(32), .ADDR_W(5), .DEPTH(D), .READ_LATENCY(L)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready[k]), .req_addr(req_addr),
      .rsp_valid(rsp_valid[k]), .rsp_ready(rsp_ready[k]),
      .rsp_instr(rsp_instr[k]), .rsp_fault(rsp_fault[k]),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    // Reference model: a FIFO of outstanding requests. The head is due once
    // it has advanced L-1 times, i.e. edges since acceptance minus stalls.
    initial begin : model
      exp_t        q[$];
      logic [31:0] mm [32];
      exp_t        e;
      int          ec = 0, sc = 0;
      bit          exp_v, stall, drained = 1'b0;
      int          idx;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          q.delete();
          chk($sformatf("d%0d rst rsp_valid", k), rsp_valid[k], 0);
          chk($sformatf("d%0d rst req_ready", k), req_ready[k], 1);
          chk($sformatf("d%0d rst rsp_instr", k), rsp_instr[k], 0);
          chk($sformatf("d%0d rst rsp_fault", k), rsp_fault[k], 0);
        end else begin
          exp_v = (q.size() > 0) && (((ec - 1 - q[0].ae) - (sc - q[0].as)) >= L - 1);
          stall = exp_v && !rsp_ready[k];
          chk($sformatf("d%0d rsp_valid", k), rsp_valid[k], exp_v);
          chk($sformatf("d%0d req_ready", k), req_ready[k], !stall);
          if (exp_v) begin
            chk($sformatf("d%0d rsp_instr", k), rsp_instr[k], q[0].d);
            chk($sformatf("d%0d rsp_fault", k), rsp_fault[k], q[0].f);
          end
          if (exp_v && rsp_ready[k]) void'(q.pop_front());
          if (stall) sc++;
          if (req_valid && !stall) begin
            idx  = int'(req_addr[6:2]);
            e.f  = (req_addr[1:0] != 2'b00) || (idx >= D);
            e.d  = e.f ? 32'h0 : mm[idx];
            e.ae = ec;
            e.as = sc;
            q.push_back(e);
          end
          if (drain_chk && !drained) begin
            chk($sformatf("d%0d drained", k), q.size(), 0);
            drained = 1'b1;
          end
        end
        if (ld_en && int'(ld_addr) < D) mm[ld_addr] = ld_data;
        ec++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    ld_en     = 1'b0;
    rsp_ready = '1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin : drive
    logic [6:0]  a1 [4];
    logic [31:0] e1 [4];
    a1 = '{7'd0, 7'd20, 7'd40, 7'd48};
    e1 = '{32'hA000_0000, 32'hA000_0005, 32'hA000_000A, 32'hA000_000C};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rsp_ready = '1;
    step(); step(); step();
    rst_n = 1'b1;
    step();

    // Program every word.
    for (int i = 0; i < 32; i++) begin
      ld_en = 1'b1; ld_addr = 5'(i); ld_data = 32'hA000_0000 + 32'(i);
      step();
    end
    idle(2);

    // Back-to-back fetches, latency-2 instance.
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = a1[i];
      step();
      if (i > 0) chk("t1 instr", rsp_instr[1], e1[i-1]);
    end
    req_valid = 1'b0;
    step();
    chk("t1 instr last", rsp_instr[1], e1[3]);
    chk("t1 valid last", rsp_valid[1], 1);
    idle(5);

    // Misaligned and out-of-range fetches.
    req_valid = 1'b1; req_addr = 7'h06; step();
    req_addr = 7'h40; step();
    req_valid = 1'b0;
    chk("t2 misaligned fault", rsp_fault[1], 1);
    chk("t2 misaligned instr", rsp_instr[1], 0);
    step();
    chk("t2 idx16 d32 fault", rsp_fault[1], 0);
    chk("t2 idx16 d32 instr", rsp_instr[1], 32'hA000_0010);
    step();
    chk("t2 d16 misaligned fault", rsp_fault[3], 1);
    step();
    chk("t2 d16 idx16 valid", rsp_valid[3], 1);
    chk("t2 d16 idx16 fault", rsp_fault[3], 1);
    chk("t2 d16 idx16 instr", rsp_instr[3], 0);
    idle(5);

    // Backpressure with two pending responses.
    rsp_ready = '0;
    req_valid = 1'b1; req_addr = 7'd4; step();
    req_addr = 7'd8; step();
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t3 req_ready stalled", req_ready[1], 0);
      chk("t3 held instr", rsp_instr[1], 32'hA000_0001);
      if (c < 2) step();
    end
    rsp_ready = '1;
    step();
    chk("t3 second instr", rsp_instr[1], 32'hA000_0002);
    chk("t3 second valid", rsp_valid[1], 1);
    step();
    chk("t3 drained", rsp_valid[1], 0);
    idle(6);

    // Same-edge load and read of word 3.
    ld_en = 1'b1; ld_addr = 5'd3; ld_data = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_addr = 7'd12; step();
    ld_en = 1'b0; step();
    req_valid = 1'b0;
    chk("t4 old data", rsp_instr[1], 32'hA000_0003);
    step();
    chk("t4 new data", rsp_instr[1], 32'hDEAD_BEEF);
    idle(5);

    // Reset with requests in flight.
    req_valid = 1'b1; req_addr = 7'd0; step();
    req_addr = 7'd4; step();
    req_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("t5 rsp_valid in reset", rsp_valid, 0);
    step(); step();
    rst_n = 1'b1;
    idle(6);
    req_valid = 1'b1; req_addr = 7'd12; step();
    req_valid = 1'b0; step();
    chk("t5 retained", rsp_instr[1], 32'hDEAD_BEEF);
    idle(5);

    // Random traffic against all four latencies.
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_addr  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : {5'($urandom), 2'b00};
      for (int k = 0; k < 4; k++) rsp_ready[k] = ($urandom_range(0, 9) < 7);
      ld_en   = ($urandom_range(0, 19) == 0);
      ld_addr = 5'($urandom);
      ld_data = $urandom;
      step();
    end
    idle(10);
    drain_chk = 1'b1;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
